// File: rtl/ov7670_reg_sequencer_if.sv
// Link between the register sequencer and the SCCB write master.
// Handshake: the sequencer raises starter with a stable add_value; the
// master performs one register write and signals completion with a rising
// edge on send. add_value changes only after a send rising edge, and
// starter stays high for the whole table.
interface ov7670_reg_sequencer_if;
    logic        starter;
    logic [15:0] add_value;
    logic        send;

    modport master (
        output starter,
        output add_value,
        input  send
    );

    modport slave (
        input  starter,
        input  add_value,
        output send
    );
endinterface

// File: rtl/ov7670_reg_sequencer.sv
// OV7670 register-table sequencer: waits a power-up interval after start,
// then feeds the SCCB write master one {addr, value} entry per completed
// write until the 16'hFFFF sentinel (or an index wrap) ends the table.
// Optional feature macro: OV7670_SEQ_WATCHDOG_EN adds a per-write timeout
// that moves the sequencer to ERR and raises err.
module ov7670_reg_sequencer #(
    parameter int PWRUP_CYCLES = 50000
`ifdef OV7670_SEQ_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 20000000
`endif
) (
    input  logic                          clk50m,
    input  logic                          rst,
    input  logic                          start,
    ov7670_reg_sequencer_if.master        sccb,
    output logic                          finish,
    output logic                          busy,
    output logic [3:0]                    index,
    output logic                          err,
    output logic [2:0]                    state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PWRUP = 3'd1,
        FETCH = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [31:0] PWRUP_LAST = 32'(PWRUP_CYCLES - 1);
    localparam logic [15:0] SENTINEL   = 16'hFFFF;

    state_t      state;
    state_t      next_state;
    logic        send_d;
    logic        send_rise;
    logic [31:0] pwr_cnt;
    logic [15:0] entry;
    logic        starter_q;
    logic [15:0] add_value_q;
    logic        finish_q;
    logic [3:0]  index_q;

`ifdef OV7670_SEQ_WATCHDOG_EN
    localparam logic [24:0] WD_LAST = 25'(TIMEOUT_CYCLES - 1);
    logic [24:0] wd_cnt;
    logic        err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign send_rise      = sccb.send & ~send_d;
    assign sccb.starter   = starter_q;
    assign sccb.add_value = add_value_q;
    assign finish         = finish_q;
    assign index          = index_q;

    // Configuration table ROM; slots after the sentinel read as sentinel.
    always_comb begin
        entry = SENTINEL;
        case (index_q)
            4'd0:    entry = 16'h1204;
            4'd1:    entry = 16'h1100;
            4'd2:    entry = 16'h0C00;
            4'd3:    entry = 16'h3E00;
            4'd4:    entry = 16'h8C00;
            4'd5:    entry = 16'h40D0;
            4'd6:    entry = 16'h3A04;
            default: entry = SENTINEL;
        endcase
    end

    // Delay register for the completion edge detector.
    always_ff @(posedge clk50m) begin
        if (rst) send_d <= 1'b0;
        else     send_d <= sccb.send;
    end

    // State register.
    always_ff @(posedge clk50m) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; start is only honoured in the non-busy states.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: if (start) next_state = PWRUP;
            PWRUP:           if (pwr_cnt == PWRUP_LAST) next_state = FETCH;
            FETCH:           next_state = (entry == SENTINEL) ? DONE : WRITE;
            WRITE: begin
                if (send_rise) next_state = (index_q == 4'd15) ? DONE : FETCH;
`ifdef OV7670_SEQ_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) next_state = ERR;
`endif
            end
            default:         next_state = IDLE;
        endcase
    end

    // Registered outputs and counters, updated per current state.
    always_ff @(posedge clk50m) begin
        if (rst) begin
            starter_q   <= 1'b0;
            add_value_q <= 16'h0000;
            finish_q    <= 1'b0;
            index_q     <= 4'd0;
            pwr_cnt     <= 32'd0;
`ifdef OV7670_SEQ_WATCHDOG_EN
            wd_cnt      <= 25'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        pwr_cnt  <= 32'd0;
                        index_q  <= 4'd0;
                        finish_q <= 1'b0;
`ifdef OV7670_SEQ_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                PWRUP: pwr_cnt <= pwr_cnt + 32'd1;
                FETCH: begin
                    add_value_q <= entry;
`ifdef OV7670_SEQ_WATCHDOG_EN
                    wd_cnt      <= 25'd0;
`endif
                    if (entry == SENTINEL) begin
                        starter_q <= 1'b0;
                        finish_q  <= 1'b1;
                    end else begin
                        starter_q <= 1'b1;
                    end
                end
                WRITE: begin
                    if (send_rise) begin
                        index_q <= index_q + 4'd1;
                        // Wrapping past the last slot ends the table.
                        if (index_q == 4'd15) begin
                            starter_q <= 1'b0;
                            finish_q  <= 1'b1;
                        end
                    end
`ifdef OV7670_SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        starter_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                    wd_cnt <= wd_cnt + 25'd1;
`endif
                end
                default: ;
            endcase
        end
    end

    // Status outputs derived from the current state.
    always_comb begin
        busy      = !(state == IDLE || state == DONE || state == ERR);
        state_dbg = state;
    end

endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// Self-checking bench for ov7670_reg_sequencer with a short power-up
// interval. Expected entries come from a table-walk model; expected timing
// is counted in cycles from the start pulse and each send rising edge.
module tb_ov7670_reg_sequencer;
    localparam int PWR = 10;
    localparam int TMO = 100;

    logic       clk50m = 1'b0;
    logic       rst    = 1'b1;
    logic       start  = 1'b0;
    logic       finish;
    logic       busy;
    logic       err;
    logic [3:0] index;
    logic [2:0] state_dbg;

    int total = 0;
    int bad   = 0;
    int exp_idx = 0;

    logic [15:0] spec_rom [16];
    logic [15:0] exp_q[$];

    ov7670_reg_sequencer_if link();

    ov7670_reg_sequencer #(
        .PWRUP_CYCLES(PWR)
`ifdef OV7670_SEQ_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk50m    (clk50m),
        .rst       (rst),
        .start     (start),
        .sccb      (link),
        .finish    (finish),
        .busy      (busy),
        .index     (index),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock
    always #10 clk50m = ~clk50m;

    task automatic tick;
        @(posedge clk50m);
        #1;
    endtask

    // Model: walk the configuration table until the sentinel or 16 entries.
    task automatic load_model;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (spec_rom[i] == 16'hFFFF) break;
            exp_q.push_back(spec_rom[i]);
        end
        exp_idx = 0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        link.send = 1'b0;
        start = 1'b0;
        tick();
        tick();
        total++;
        if (link.starter !== 1'b0 || link.add_value !== 16'h0000 || finish !== 1'b0 ||
            busy !== 1'b0 || index !== 4'd0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_values got starter=%b add=%h fin=%b busy=%b idx=%0d err=%b want 0/0000/0/0/0/0",
                     link.starter, link.add_value, finish, busy, index, err);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0 || link.starter !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b starter=%b want 0/0", busy, link.starter);
        end
    endtask

    // Start pulse, power-up wait, first write presented at cycle PWR+2.
    task automatic test_startup;
        load_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || finish !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL startup_enter got busy=%b fin=%b err=%b want 1/0/0", busy, finish, err);
        end
        repeat (PWR) tick();
        total++;
        if (link.starter !== 1'b0) begin
            bad++;
            $display("FAIL startup_early got starter=%b want 0", link.starter);
        end
        tick();
        total++;
        if (link.starter !== 1'b1 || link.add_value !== exp_q[0] || busy !== 1'b1 || index !== 4'd0) begin
            bad++;
            $display("FAIL startup_first got starter=%b add=%h busy=%b idx=%0d want 1/%h/1/0",
                     link.starter, link.add_value, busy, index, exp_q[0]);
        end
    endtask

    // Complete `count` writes. fixed_gap>0 fixes the cycles before send;
    // otherwise random. poke pulses start during writes (must be ignored).
    task automatic test_entries(input int count, input int fixed_gap, input int hold_max, input bit poke);
        for (int i = 0; i < count; i++) begin
            logic [15:0] cur;
            int g;
            int h;
            cur = exp_q.pop_front();
            g = (fixed_gap > 0) ? fixed_gap : int'($urandom_range(1, 6));
            repeat (g) begin
                if (poke && $urandom_range(0, 2) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            total++;
            if (link.starter !== 1'b1 || link.add_value !== cur || index !== 4'(exp_idx) || busy !== 1'b1) begin
                bad++;
                $display("FAIL write_hold got starter=%b add=%h idx=%0d busy=%b want 1/%h/%0d/1",
                         link.starter, link.add_value, index, busy, cur, exp_idx);
            end
            h = int'($urandom_range(2, hold_max));
            link.send = 1'b1;
            for (int k = 0; k < h; k++) begin
                tick();
                if (k == 1) begin
                    exp_idx = (exp_idx + 1) % 16;
                    total++;
                    if (exp_q.size() == 0) begin
                        if (link.starter !== 1'b0 || finish !== 1'b1 || busy !== 1'b0 || index !== 4'(exp_idx)) begin
                            bad++;
                            $display("FAIL table_end got starter=%b fin=%b busy=%b idx=%0d want 0/1/0/%0d",
                                     link.starter, finish, busy, index, exp_idx);
                        end
                    end else begin
                        if (link.starter !== 1'b1 || link.add_value !== exp_q[0] || index !== 4'(exp_idx)) begin
                            bad++;
                            $display("FAIL advance got starter=%b add=%h idx=%0d want 1/%h/%0d",
                                     link.starter, link.add_value, index, exp_q[0], exp_idx);
                        end
                    end
                end
            end
            link.send = 1'b0;
        end
    endtask

    // finish is a level; send edges in DONE must not move anything.
    task automatic test_done_level;
        repeat (int'($urandom_range(2, 5))) tick();
        link.send = 1'b1;
        tick();
        tick();
        link.send = 1'b0;
        repeat (3) tick();
        total++;
        if (finish !== 1'b1 || link.starter !== 1'b0 || busy !== 1'b0 || index !== 4'(exp_idx)) begin
            bad++;
            $display("FAIL done_level got fin=%b starter=%b busy=%b idx=%0d want 1/0/0/%0d",
                     finish, link.starter, busy, index, exp_idx);
        end
    endtask

    task automatic test_reset_mid_write;
        test_startup();
        test_entries(3, 0, 4, 1'b0);
        repeat (int'($urandom_range(1, 4))) tick();
        rst = 1'b1;
        tick();
        total++;
        if (link.starter !== 1'b0 || index !== 4'd0 || link.add_value !== 16'h0000 ||
            busy !== 1'b0 || finish !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_write got starter=%b idx=%0d add=%h busy=%b fin=%b want 0/0/0000/0/0",
                     link.starter, index, link.add_value, busy, finish);
        end
        rst = 1'b0;
        tick();
        test_startup();
        test_entries(7, 0, 5, 1'b1);
    endtask

`ifdef OV7670_SEQ_WATCHDOG_EN
    task automatic test_watchdog;
        test_startup();
        repeat (TMO - 1) tick();
        total++;
        if (err !== 1'b0 || link.starter !== 1'b1) begin
            bad++;
            $display("FAIL wd_early got err=%b starter=%b want 0/1", err, link.starter);
        end
        tick();
        total++;
        if (err !== 1'b1 || link.starter !== 1'b0 || finish !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wd_timeout got err=%b starter=%b fin=%b busy=%b want 1/0/0/0",
                     err, link.starter, finish, busy);
        end
        test_startup();
        test_entries(7, 0, 4, 1'b0);
        test_done_level();
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) spec_rom[i] = 16'hFFFF;
        spec_rom[0] = 16'h1204;
        spec_rom[1] = 16'h1100;
        spec_rom[2] = 16'h0C00;
        spec_rom[3] = 16'h3E00;
        spec_rom[4] = 16'h8C00;
        spec_rom[5] = 16'h40D0;
        spec_rom[6] = 16'h3A04;
        link.send = 1'b0;

        test_reset();
        test_startup();
        test_entries(7, 5, 2, 1'b0);
        test_done_level();
        test_startup();
        test_entries(7, 0, 6, 1'b1);
        test_done_level();
        test_reset_mid_write();
        test_done_level();
`ifdef OV7670_SEQ_WATCHDOG_EN
        test_watchdog();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
